// File: rtl/str_ppl_pkg.sv
// Shared helpers for the str_ppl family of stream blocks: width math, pointer wrap
// and parameter legality.
package str_ppl_pkg;

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a storage array of `slots` entries; never narrower than 1 bit.
  function automatic int unsigned ptr_w(input int unsigned slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

  // Explicit wrap so non-power-of-2 storage sizes work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned slots);
    return (ptr + 1 >= slots) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned afull_th);
    return (depth >= 2) && (afull_th >= 1) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/str_ppl_fifo.sv
// Valid/ready stream FIFO with registered handshakes, first-word-fall-through output
// register, occupancy flags and synchronous flush.
module str_ppl_fifo
  import str_ppl_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = DEPTH - 1,
  parameter string       SIM      = "FALSE",
  parameter string       DEBUG    = "FALSE"
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic [WIDTH-1:0]          inp_str_data,
  input  logic                      inp_str_vld,
  output logic                      inp_str_rdy,
  output logic [WIDTH-1:0]          oup_str_data,
  output logic                      oup_str_vld,
  input  logic                      oup_str_rdy,
  output logic [lvl_w(DEPTH)-1:0]   o_level,
  output logic                      o_empty,
  output logic                      o_afull
);

  localparam int unsigned NS     = DEPTH - 1;
  localparam int unsigned LW     = lvl_w(DEPTH);
  localparam int unsigned PW     = ptr_w(NS);
  localparam bit          DbgEn  = (DEBUG == "TRUE");

  if (!params_ok(DEPTH, AFULL_TH)) begin : g_bad_params
    $error("str_ppl_fifo: illegal DEPTH/AFULL_TH combination");
  end

  logic [WIDTH-1:0] mem [NS];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d, rdy_q, rdy_d, empty_q, empty_d, afull_q, afull_d;
  logic             push, pop, stor_any, rd_en, wr_en, bypass;

  always_comb begin
    push     = inp_str_vld & rdy_q;
    pop      = vld_q & oup_str_rdy;
    // Storage holds level-1 words whenever the output register is occupied.
    stor_any = (level_q > LW'(1));
    rd_en    = pop & stor_any & ~i_flush;
    bypass   = push & (~vld_q | (pop & ~stor_any)) & ~i_flush;
    wr_en    = push & ~bypass & ~i_flush;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    data_d   = data_q;

    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      level_d = level_q + LW'(push) - LW'(pop);
      if (rd_en) begin
        data_d   = mem[rd_ptr_q];
        rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), NS));
      end
      if (bypass) data_d = inp_str_data;
      if (wr_en) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), NS));
    end

    vld_d   = (level_d != '0);
    rdy_d   = (level_d < LW'(DEPTH)) & ~i_flush;
    empty_d = (level_d == '0);
    afull_d = (level_d >= LW'(AFULL_TH));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
    end
  end

  // Data array is deliberately unreset. In debug builds a drained slot is zeroed so
  // stale words are easy to tell apart from live ones in waveforms.
  always_ff @(posedge i_clk) begin
    if (DbgEn && rd_en) mem[rd_ptr_q] <= '0;
    if (wr_en) mem[wr_ptr_q] <= inp_str_data;
  end

  assign inp_str_rdy  = rdy_q;
  assign oup_str_data = data_q;
  assign oup_str_vld  = vld_q;
  assign o_level      = level_q;
  assign o_empty      = empty_q;
  assign o_afull      = afull_q;

  if (SIM == "TRUE") begin : g_sim_chk
    always @(posedge i_clk) begin
      if (!i_rst) begin
        assert (!(push && (level_q == LW'(DEPTH))));
        assert (!(pop && (level_q == '0)));
        assert (level_q <= LW'(DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_str_ppl_fifo.sv
// Scoreboard bench for str_ppl_fifo: every cycle compares handshakes, flags and head
// word against a queue model of the buffer contents.
module tb_str_ppl_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = 3;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             i_clk, i_rst, i_flush;
  logic [WIDTH-1:0] inp_str_data, oup_str_data;
  logic             inp_str_vld, inp_str_rdy, oup_str_vld, oup_str_rdy;
  logic [LW-1:0]    o_level;
  logic             o_empty, o_afull;

  str_ppl_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL),
    .SIM      ("TRUE"),
    .DEBUG    ("TRUE")
  ) u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .inp_str_data (inp_str_data),
    .inp_str_vld  (inp_str_vld),
    .inp_str_rdy  (inp_str_rdy),
    .oup_str_data (oup_str_data),
    .oup_str_vld  (oup_str_vld),
    .oup_str_rdy  (oup_str_rdy),
    .o_level      (o_level),
    .o_empty      (o_empty),
    .o_afull      (o_afull)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb[$];
  logic        rdy_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy"}, 32'(inp_str_rdy), 32'd0);
    check_eq({tag, "_vld"}, 32'(oup_str_vld), 32'd0);
    check_eq({tag, "_lvl"}, 32'(o_level), 32'd0);
    check_eq({tag, "_empty"}, 32'(o_empty), 32'd1);
    check_eq({tag, "_afull"}, 32'(o_afull), 32'd0);
    check_eq({tag, "_data"}, oup_str_data, 32'd0);
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, updates the model at posedge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f,
                       output logic acc);
    logic pp;
    int   n;
    inp_str_vld  = v;
    inp_str_data = d;
    oup_str_rdy  = r;
    i_flush      = f;
    @(negedge i_clk);
    n = sb.size();
    check_eq("rdy", 32'(inp_str_rdy), 32'(rdy_exp));
    check_eq("vld", 32'(oup_str_vld), 32'(n != 0));
    check_eq("level", 32'(o_level), 32'(n));
    check_eq("empty", 32'(o_empty), 32'(n == 0));
    check_eq("afull", 32'(o_afull), 32'(n >= AFULL));
    if (n != 0) check_eq("head", oup_str_data, sb[0]);
    acc = v & inp_str_rdy & ~f;
    pp  = oup_str_vld & r & ~f;
    @(posedge i_clk);
    if (f) begin
      sb.delete();
    end else begin
      if (pp && sb.size() != 0) void'(sb.pop_front());
      if (acc) sb.push_back(d);
    end
    rdy_exp = (sb.size() < DEPTH) && !f;
    #1;
  endtask

  task automatic drain(input int limit);
    logic acc;
    int   c = 0;
    while (sb.size() != 0 && c < limit) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
      c++;
    end
    if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] w;
    int          c;

    i_rst = 1'b1; i_flush = 1'b0; inp_str_vld = 1'b0; inp_str_data = '0; oup_str_rdy = 1'b0;
    rdy_exp = 1'b0;
    #1;
    check_reset_vals("rst0");
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_vals("rst1");
    i_rst = 1'b0;
    cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);

    // Consumer stalled, six words offered back to back.
    w = 32'd1;
    repeat (6) begin
      cycle(1'b1, w, 1'b0, 1'b0, acc);
      if (acc) w++;
    end
    check_eq("stall_accepted", w, 32'd5);
    check_eq("stall_lvl", 32'(o_level), 32'(DEPTH));
    check_eq("stall_rdy", 32'(inp_str_rdy), 32'd0);
    c = 0;
    while (w <= 32'd6 && c < 20) begin
      cycle(1'b1, w, 1'b1, 1'b0, acc);
      if (acc) w++;
      c++;
    end
    check_eq("stall_rest", w, 32'd7);
    drain(20);

    // Both sides always ready.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, acc);
      check_eq("stream_acc", 32'(acc), 32'd1);
    end
    drain(10);

    // Random valid/ready at 50 %.
    w = 32'h1000;
    c = 0;
    while (w < 32'h1000 + 32'd4000 && c < 40000) begin
      cycle(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) w++;
      c++;
    end
    check_eq("rand_words", w, 32'h1000 + 32'd4000);
    drain(50);

    // Flush at level 3 with simultaneous push and pop.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, acc);
    check_eq("pre_flush_lvl", 32'(o_level), 32'd3);
    cycle(1'b1, 32'hF1, 1'b1, 1'b1, acc);
    check_eq("flush_lvl", 32'(o_level), 32'd0);
    check_eq("flush_vld", 32'(oup_str_vld), 32'd0);
    check_eq("flush_rdy", 32'(inp_str_rdy), 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
    check_eq("post_flush_rdy", 32'(inp_str_rdy), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0, acc);
    drain(10);

    // Asynchronous reset mid-burst at level 2.
    for (int i = 0; i < 2; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, acc);
    check_eq("pre_rst_lvl", 32'(o_level), 32'd2);
    inp_str_vld = 1'b1; oup_str_rdy = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    sb.delete();
    rdy_exp = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'($urandom_range(0, 1)), 1'b0, acc);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
